// File: rtl/fc1_pkg.sv
// FC1 shared types: the interval-statistics record passed from the
// collector to the readout/DMA logic.
package fc1_pkg;

  typedef struct packed {
    logic [31:0] enc_full_cnt;
    logic [31:0] enc_empty_cnt;
    logic [31:0] corr_event_cnt;
    logic [31:0] uncorr_event_cnt;
    logic [31:0] pcs_los_cnt;
  } fc1_interval_stats;

endpackage

// File: rtl/fc1_intstat_collect.sv
// FC1 interval-statistics producer: counts PCS/FEC event strobes, snapshots
// the counts on each interval tick and offers the record over valid/ack.
module fc1_intstat_collect #(
  parameter bit LOS_EDGE = 1'b1,
  parameter bit SATURATE = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stat_en,
  input  logic                          interval_tick,
  input  logic                          enc_full,
  input  logic                          enc_empty,
  input  logic                          corr_event,
  input  logic                          uncorr_event,
  input  logic                          pcs_los,
  output fc1_pkg::fc1_interval_stats    stats,
  output logic                          stats_valid,
  input  logic                          stats_ack,
  output logic                          stats_overrun
);

  import fc1_pkg::*;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t            state_q;
  fc1_interval_stats stats_q;
  logic              stats_valid_q;
  logic              stats_overrun_q;

  logic              los_prev_q, los_prev_d;
  logic [31:0]       enc_full_cnt_q,     enc_full_cnt_d;
  logic [31:0]       enc_empty_cnt_q,    enc_empty_cnt_d;
  logic [31:0]       corr_event_cnt_q,   corr_event_cnt_d;
  logic [31:0]       uncorr_event_cnt_q, uncorr_event_cnt_d;
  logic [31:0]       pcs_los_cnt_q,      pcs_los_cnt_d;

  logic              los_act;
  logic [4:0]        inc;
  fc1_interval_stats snap;

  // One-step counter advance; holds at all-ones when saturating, else wraps.
  function automatic logic [31:0] bump(input logic [31:0] c, input logic en);
    if (!en)
      return c;
    if (SATURATE && (c == 32'hFFFF_FFFF))
      return c;
    return c + 32'd1;
  endfunction

  // Event qualification and the tick-cycle snapshot (count plus this cycle's event).
  always_comb begin
    los_act = LOS_EDGE ? (pcs_los & ~los_prev_q) : pcs_los;
    inc     = {enc_full, enc_empty, corr_event, uncorr_event, los_act} & {5{stat_en}};

    snap.enc_full_cnt     = bump(enc_full_cnt_q,     inc[4]);
    snap.enc_empty_cnt    = bump(enc_empty_cnt_q,    inc[3]);
    snap.corr_event_cnt   = bump(corr_event_cnt_q,   inc[2]);
    snap.uncorr_event_cnt = bump(uncorr_event_cnt_q, inc[1]);
    snap.pcs_los_cnt      = bump(pcs_los_cnt_q,      inc[0]);
  end

  // Next running counts: cleared on the tick so tick-cycle events live only in the snapshot.
  always_comb begin
    los_prev_d         = pcs_los;
    enc_full_cnt_d     = interval_tick ? 32'd0 : snap.enc_full_cnt;
    enc_empty_cnt_d    = interval_tick ? 32'd0 : snap.enc_empty_cnt;
    corr_event_cnt_d   = interval_tick ? 32'd0 : snap.corr_event_cnt;
    uncorr_event_cnt_d = interval_tick ? 32'd0 : snap.uncorr_event_cnt;
    pcs_los_cnt_d      = interval_tick ? 32'd0 : snap.pcs_los_cnt;
  end

  // Running counter and LOS edge-detect registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      los_prev_q         <= 1'b0;
      enc_full_cnt_q     <= 32'd0;
      enc_empty_cnt_q    <= 32'd0;
      corr_event_cnt_q   <= 32'd0;
      uncorr_event_cnt_q <= 32'd0;
      pcs_los_cnt_q      <= 32'd0;
    end else begin
      los_prev_q         <= los_prev_d;
      enc_full_cnt_q     <= enc_full_cnt_d;
      enc_empty_cnt_q    <= enc_empty_cnt_d;
      corr_event_cnt_q   <= corr_event_cnt_d;
      uncorr_event_cnt_q <= uncorr_event_cnt_d;
      pcs_los_cnt_q      <= pcs_los_cnt_d;
    end
  end

  // Handshake FSM: holds the snapshot until acked; a tick while pending
  // replaces it, flagging overrun only when the old one was not acked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      stats_q         <= '0;
      stats_valid_q   <= 1'b0;
      stats_overrun_q <= 1'b0;
    end else begin
      stats_overrun_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (interval_tick) begin
            stats_q       <= snap;
            stats_valid_q <= 1'b1;
            state_q       <= PEND;
          end
        end
        PEND: begin
          if (interval_tick) begin
            stats_q         <= snap;
            stats_overrun_q <= ~stats_ack;
          end else if (stats_ack) begin
            stats_valid_q <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: begin
          stats_valid_q <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  assign stats         = stats_q;
  assign stats_valid   = stats_valid_q;
  assign stats_overrun = stats_overrun_q;

endmodule

// File: tb/tb_fc1_intstat_collect.sv
// Directed bench for fc1_intstat_collect: default instance plus a level-LOS
// instance and a wrapping-counter instance, all driven by the same inputs.
module tb_fc1_intstat_collect;

  logic         clk = 1'b0;
  logic         rst;
  logic         stat_en;
  logic         interval_tick;
  logic         enc_full;
  logic         enc_empty;
  logic         corr_event;
  logic         uncorr_event;
  logic         pcs_los;
  logic         stats_ack;

  logic [159:0] stats,     stats_lvl,     stats_wrp;
  logic         valid,     valid_lvl,     valid_wrp;
  logic         overrun,   overrun_lvl,   overrun_wrp;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fc1_intstat_collect #(.LOS_EDGE(1'b1), .SATURATE(1'b1)) dut (
    .clk(clk), .rst(rst), .stat_en(stat_en), .interval_tick(interval_tick),
    .enc_full(enc_full), .enc_empty(enc_empty), .corr_event(corr_event),
    .uncorr_event(uncorr_event), .pcs_los(pcs_los), .stats(stats),
    .stats_valid(valid), .stats_ack(stats_ack), .stats_overrun(overrun)
  );

  fc1_intstat_collect #(.LOS_EDGE(1'b0), .SATURATE(1'b1)) dut_lvl (
    .clk(clk), .rst(rst), .stat_en(stat_en), .interval_tick(interval_tick),
    .enc_full(enc_full), .enc_empty(enc_empty), .corr_event(corr_event),
    .uncorr_event(uncorr_event), .pcs_los(pcs_los), .stats(stats_lvl),
    .stats_valid(valid_lvl), .stats_ack(stats_ack), .stats_overrun(overrun_lvl)
  );

  fc1_intstat_collect #(.LOS_EDGE(1'b1), .SATURATE(1'b0)) dut_wrp (
    .clk(clk), .rst(rst), .stat_en(stat_en), .interval_tick(interval_tick),
    .enc_full(enc_full), .enc_empty(enc_empty), .corr_event(corr_event),
    .uncorr_event(uncorr_event), .pcs_los(pcs_los), .stats(stats_wrp),
    .stats_valid(valid_wrp), .stats_ack(stats_ack), .stats_overrun(overrun_wrp)
  );

  typedef struct {
    int           full;
    int           empty;
    int           corr;
    int           uncorr;
    int           all4;
    logic [159:0] exp;
  } vec_t;

  vec_t tbl[5];

  function automatic logic [159:0] mk(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c, input logic [31:0] d,
                                      input logic [31:0] e);
    return {a, b, c, d, e};
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    interval_tick = 1'b1;
    step();
    interval_tick = 1'b0;
  endtask

  task automatic do_ack();
    stats_ack = 1'b1;
    step();
    stats_ack = 1'b0;
  endtask

  initial begin
    tbl[0] = '{10, 0, 3, 2, 0, mk(32'd10, 32'd0, 32'd3, 32'd2, 32'd0)};
    tbl[1] = '{0, 4, 0, 0, 0, mk(32'd0, 32'd4, 32'd0, 32'd0, 32'd0)};
    tbl[2] = '{0, 0, 0, 0, 3, mk(32'd3, 32'd3, 32'd3, 32'd3, 32'd0)};
    tbl[3] = '{2, 1, 0, 5, 2, mk(32'd4, 32'd3, 32'd2, 32'd7, 32'd0)};
    tbl[4] = '{0, 0, 0, 0, 0, mk(32'd0, 32'd0, 32'd0, 32'd0, 32'd0)};

    rst = 1'b1; stat_en = 1'b1; interval_tick = 1'b0; enc_full = 1'b0;
    enc_empty = 1'b0; corr_event = 1'b0; uncorr_event = 1'b0; pcs_los = 1'b0;
    stats_ack = 1'b0;
    step(); step();
    chk("reset_stats", stats, '0);
    chk("reset_valid", {159'd0, valid}, 160'd0);
    chk("reset_overrun", {159'd0, overrun}, 160'd0);
    rst = 1'b0;
    step();

    // Table-driven intervals
    for (int v = 0; v < 5; v++) begin
      enc_full = 1'b1;     for (int i = 0; i < tbl[v].full; i++) step();   enc_full = 1'b0;
      enc_empty = 1'b1;    for (int i = 0; i < tbl[v].empty; i++) step();  enc_empty = 1'b0;
      corr_event = 1'b1;   for (int i = 0; i < tbl[v].corr; i++) step();   corr_event = 1'b0;
      uncorr_event = 1'b1; for (int i = 0; i < tbl[v].uncorr; i++) step(); uncorr_event = 1'b0;
      {enc_full, enc_empty, corr_event, uncorr_event} = 4'hF;
      for (int i = 0; i < tbl[v].all4; i++) step();
      {enc_full, enc_empty, corr_event, uncorr_event} = 4'h0;
      chk($sformatf("vec%0d_valid_before_tick", v), {159'd0, valid}, 160'd0);
      do_tick();
      chk($sformatf("vec%0d_valid", v), {159'd0, valid}, 160'd1);
      chk($sformatf("vec%0d_stats", v), stats, tbl[v].exp);
      do_ack();
      chk($sformatf("vec%0d_valid_after_ack", v), {159'd0, valid}, 160'd0);
    end

    // LOS edge vs level counting
    pcs_los = 1'b1; repeat (50) step();
    pcs_los = 1'b0; repeat (5) step();
    pcs_los = 1'b1; repeat (7) step();
    pcs_los = 1'b0;
    do_tick();
    chk("los_edge_cnt", stats, mk(0, 0, 0, 0, 32'd2));
    chk("los_level_cnt", stats_lvl, mk(0, 0, 0, 0, 32'd57));
    do_ack();

    // Ack while idle is ignored; the following tick still raises valid
    do_ack();
    chk("idle_ack_valid", {159'd0, valid}, 160'd0);
    do_tick();
    chk("tick_after_idle_ack", {159'd0, valid}, 160'd1);

    // Overrun: pending snapshot not acked, 4 enc_empty, second tick
    enc_empty = 1'b1; repeat (4) step(); enc_empty = 1'b0;
    chk("pend_stats_frozen", stats, '0);
    do_tick();
    chk("overrun_pulse", {159'd0, overrun}, 160'd1);
    chk("overrun_stats", stats, mk(0, 32'd4, 0, 0, 0));
    chk("overrun_valid", {159'd0, valid}, 160'd1);
    step();
    chk("overrun_one_cycle", {159'd0, overrun}, 160'd0);
    // ack together with tick: new snapshot, no overrun
    corr_event = 1'b1; repeat (2) step(); corr_event = 1'b0;
    stats_ack = 1'b1; interval_tick = 1'b1;
    step();
    stats_ack = 1'b0; interval_tick = 1'b0;
    chk("acktick_no_overrun", {159'd0, overrun}, 160'd0);
    chk("acktick_valid", {159'd0, valid}, 160'd1);
    chk("acktick_stats", stats, mk(0, 0, 32'd2, 0, 0));
    do_ack();
    chk("acktick_release", {159'd0, valid}, 160'd0);

    // Saturation vs wrap from a preloaded counter
    force dut.enc_full_cnt_q = 32'hFFFF_FFFE;
    force dut_wrp.enc_full_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.enc_full_cnt_q;
    release dut_wrp.enc_full_cnt_q;
    enc_full = 1'b1; repeat (3) step(); enc_full = 1'b0;
    do_tick();
    chk("saturate", stats, mk(32'hFFFF_FFFF, 0, 0, 0, 0));
    chk("wrap", stats_wrp, mk(32'd1, 0, 0, 0, 0));
    do_ack();

    // stat_en gating, tick-cycle event inclusion and non-carry
    stat_en = 1'b0; corr_event = 1'b1; repeat (20) step();
    stat_en = 1'b1; repeat (5) step(); corr_event = 1'b0;
    do_tick();
    chk("stat_en_gate", stats, mk(0, 0, 32'd5, 0, 0));
    do_ack();
    corr_event = 1'b1; repeat (5) step();
    do_tick();
    corr_event = 1'b0;
    chk("tick_cycle_event", stats, mk(0, 0, 32'd6, 0, 0));
    do_ack();
    do_tick();
    chk("tick_event_not_carried", stats, '0);
    do_ack();

    // Back-to-back ticks: second snapshot has only its own cycle's events
    enc_full = 1'b1; repeat (3) step();
    interval_tick = 1'b1;
    step();
    chk("b2b_first", stats, mk(32'd4, 0, 0, 0, 0));
    step();
    interval_tick = 1'b0; enc_full = 1'b0;
    chk("b2b_second", stats, mk(32'd1, 0, 0, 0, 0));
    chk("b2b_overrun", {159'd0, overrun}, 160'd1);
    do_ack();

    // Async reset mid-PEND discards everything
    enc_full = 1'b1; repeat (8) step(); enc_full = 1'b0;
    do_tick();
    uncorr_event = 1'b1; repeat (8) step(); uncorr_event = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_stats", stats, '0);
    chk("async_rst_valid", {159'd0, valid}, 160'd0);
    step();
    #2 rst = 1'b0;
    step();
    chk("post_rst_overrun", {159'd0, overrun}, 160'd0);
    do_tick();
    chk("post_rst_valid", {159'd0, valid}, 160'd1);
    chk("post_rst_stats", stats, '0);
    do_ack();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
